// File: rtl/seqdet_pkg.sv
// ============================================================================
// Module   : seqdet_pkg
// Purpose  : Shared sizing and mode constants for the serial pattern detector.
// Revision : 1.0
// ============================================================================
`default_nettype none

package seqdet_pkg;

  localparam int   MAX_LEN     = 16;
  localparam int   FILL_W      = 5;
  localparam logic MODE_NONOVL = 1'b0;
  localparam logic MODE_OVL    = 1'b1;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module   : sat_counter
// Purpose  : W-bit up counter that sticks at all-ones; synchronous clear wins.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/seq_detector_param.sv
// ============================================================================
// Module   : seq_detector_param
// Purpose  : Run-time loadable Mealy serial pattern detector, LEN 2..16, with
//            per-cycle overlap select. Define SEQDET_MATCH_COUNT_EN to add the
//            saturating match_cnt output.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_detector_param
  import seqdet_pkg::*;
#(
  parameter int             LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = 4'b1010,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x_valid,
  input  logic             x,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [LEN-1:0]   pat_in,
  output logic             z
`ifdef SEQDET_MATCH_COUNT_EN
  ,
  output logic [CNT_W-1:0] match_cnt
`endif
);

  localparam logic [FILL_W-1:0] c_fill_max = FILL_W'(LEN - 1);

  if ((LEN < 2) || (LEN > MAX_LEN)) begin : g_bad_len
    $error("seq_detector_param: LEN must be in 2..16");
  end
  if ((CNT_W < 1) || (CNT_W > 32)) begin : g_bad_cnt_w
    $error("seq_detector_param: CNT_W must be in 1..32");
  end

  logic [LEN-1:0]    r_pat;
  logic [LEN-2:0]    r_hist;
  logic [FILL_W-1:0] r_fill;
  logic [LEN-2:0]    w_hist_next;
  logic [FILL_W-1:0] w_fill_next;
  logic              w_accept;
  logic              w_match;

  if (LEN == 2) begin : g_hist_single
    assign w_hist_next = x;
  end else begin : g_hist_shift
    assign w_hist_next = {r_hist[LEN-3:0], x};
  end

  assign w_accept = x_valid && !pat_load;
  assign w_match  = !rst && w_accept && (r_fill == c_fill_max) && ({r_hist, x} == r_pat);
  assign z        = w_match;

  // A non-overlapping match empties the history so the next match needs LEN fresh bits.
  always_comb begin
    w_fill_next = r_fill;
    if (w_match && (overlap == MODE_NONOVL)) begin
      w_fill_next = '0;
    end else if (w_match && (overlap == MODE_OVL)) begin
      w_fill_next = c_fill_max;
    end else if (r_fill != c_fill_max) begin
      w_fill_next = r_fill + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pat  <= PATTERN;
      r_hist <= '0;
      r_fill <= '0;
    end else if (pat_load) begin
      r_pat  <= pat_in;
      r_fill <= '0;
    end else if (x_valid) begin
      r_hist <= w_hist_next;
      r_fill <= w_fill_next;
    end
  end

`ifdef SEQDET_MATCH_COUNT_EN
  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .i_clr (rst),
    .i_inc (w_match),
    .o_cnt (match_cnt)
  );
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_detector_param.sv
// ============================================================================
// Module   : tb_seq_detector_param
// Purpose  : Directed bench for seq_detector_param with a queue-based model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seq_detector_param;

  localparam int           LEN   = 4;
  localparam logic [3:0]   PAT   = 4'b1010;
  localparam int           CNT_W = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       x_valid = 1'b0;
  logic       x = 1'b0;
  logic       overlap = 1'b0;
  logic       pat_load = 1'b0;
  logic [3:0] pat_in = 4'b0000;
  logic       z;

  logic       x_valid2 = 1'b0;
  logic       x2 = 1'b0;
  logic       z2;

`ifdef SEQDET_MATCH_COUNT_EN
  logic [CNT_W-1:0] cnt;
  logic [1:0]       cnt2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_detector_param #(
    .LEN     (LEN),
    .PATTERN (PAT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .x_valid  (x_valid),
    .x        (x),
    .overlap  (overlap),
    .pat_load (pat_load),
    .pat_in   (pat_in),
    .z        (z)
`ifdef SEQDET_MATCH_COUNT_EN
    ,
    .match_cnt (cnt)
`endif
  );

  seq_detector_param #(
    .LEN     (2),
    .PATTERN (2'b11),
    .CNT_W   (2)
  ) dut2 (
    .clk      (clk),
    .rst      (rst),
    .x_valid  (x_valid2),
    .x        (x2),
    .overlap  (1'b1),
    .pat_load (1'b0),
    .pat_in   (2'b11),
    .z        (z2)
`ifdef SEQDET_MATCH_COUNT_EN
    ,
    .match_cnt (cnt2)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the last LEN-1 accepted bits since the last restart, oldest first.
  bit         mq[$];
  logic [3:0] mpat = PAT;
  int         mcnt = 0;

  function automatic logic model_z();
    logic [3:0] v;
    if (rst || !x_valid || pat_load || (mq.size() != LEN - 1)) return 1'b0;
    for (int i = 0; i < LEN - 1; i++) v[LEN-1-i] = mq[i];
    v[0] = x;
    return v == mpat;
  endfunction

  always @(posedge clk) begin : p_model
    logic zz;
    zz = model_z();
    if (rst) begin
      mq.delete();
      mpat = PAT;
      mcnt = 0;
    end else if (pat_load) begin
      mpat = pat_in;
      mq.delete();
    end else if (x_valid) begin
      mq.push_back(x);
      if (mq.size() > LEN - 1) void'(mq.pop_front());
      if (zz) begin
        if (mcnt < (1 << CNT_W) - 1) mcnt++;
        if (!overlap) mq.delete();
      end
    end
  end

  always @(negedge clk) begin
    chk("z_vs_model", {31'd0, z}, {31'd0, model_z()});
`ifdef SEQDET_MATCH_COUNT_EN
    chk("cnt_vs_model", {24'd0, cnt}, mcnt);
`endif
  end

  task automatic chk_cnt(input int exp);
`ifdef SEQDET_MATCH_COUNT_EN
    chk("match_cnt", {24'd0, cnt}, exp);
`endif
  endtask

  task automatic send(input logic b, input logic exp, input string nm);
    x_valid = 1'b1;
    x       = b;
    @(negedge clk);
    chk(nm, {31'd0, z}, {31'd0, exp});
    @(posedge clk);
    #1;
    x_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    x_valid = 1'b0;
    x       = 1'b1;
    repeat (n) begin
      @(negedge clk);
      chk("gap_z", {31'd0, z}, 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  // Reset with a qualifying 0 on x, so a pending 1,0,1 history would otherwise match.
  task automatic do_reset();
    rst     = 1'b1;
    x_valid = 1'b1;
    x       = 1'b0;
    @(negedge clk);
    chk("rst_forces_z0", {31'd0, z}, 32'd0);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    x_valid = 1'b0;
  endtask

  task automatic load(input logic [3:0] p);
    pat_load = 1'b1;
    pat_in   = p;
    x_valid  = 1'b1;
    x        = 1'b0;
    @(negedge clk);
    chk("load_z", {31'd0, z}, 32'd0);
    @(posedge clk);
    #1;
    pat_load = 1'b0;
    x_valid  = 1'b0;
  endtask

  task automatic send2(input logic exp);
    x_valid2 = 1'b1;
    x2       = 1'b1;
    @(negedge clk);
    chk("len2_z", {31'd0, z2}, {31'd0, exp});
    @(posedge clk);
    #1;
    x_valid2 = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_z", {31'd0, z}, 32'd0);
    chk_cnt(0);

    overlap = 1'b0;
    send(1, 0, "nonovl_b1"); send(0, 0, "nonovl_b2"); send(1, 0, "nonovl_b3");
    send(0, 1, "nonovl_b4"); send(1, 0, "nonovl_b5"); send(0, 0, "nonovl_b6");
    chk_cnt(1);

    do_reset();
    overlap = 1'b1;
    send(1, 0, "ovl_b1"); send(0, 0, "ovl_b2"); send(1, 0, "ovl_b3");
    send(0, 1, "ovl_b4"); send(1, 0, "ovl_b5"); send(0, 1, "ovl_b6");
    chk_cnt(2);

    do_reset();
    overlap = 1'b0;
    send(1, 0, "gap_b1"); send(0, 0, "gap_b2");
    idle(3);
    send(1, 0, "gap_b3"); send(0, 1, "gap_b4");
    chk_cnt(1);

    send(1, 0, "pre_load_b1"); send(0, 0, "pre_load_b2"); send(1, 0, "pre_load_b3");
    load(4'b1100);
    send(1, 0, "ld_b1"); send(1, 0, "ld_b2"); send(0, 0, "ld_b3"); send(0, 1, "ld_b4");
    chk_cnt(2);

    do_reset();
    send(1, 0, "pre_rst_b1"); send(0, 0, "pre_rst_b2"); send(1, 0, "pre_rst_b3");
    do_reset();
    send(0, 0, "post_rst_b0");
    send(1, 0, "post_rst_b1"); send(0, 0, "post_rst_b2");
    send(1, 0, "post_rst_b3"); send(0, 1, "post_rst_b4");
    chk_cnt(1);

    do_reset();
    send2(0); send2(1); send2(1); send2(1); send2(1); send2(1);
`ifdef SEQDET_MATCH_COUNT_EN
    chk("len2_cnt_sat", {30'd0, cnt2}, 32'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
